// File: rtl/simt_reconv_stack_if.sv
// Signal bundle between Issue/Execute/Fetch and the per-warp SIMT reconvergence stack.
// "master" is the pipeline side and "slave" is the stack.
interface simt_reconv_stack_if #(
    parameter int NUM_WARP_LOG = 3,
    parameter int SIZE_CORE    = 8,
    parameter int SIZE_PC      = 32
);
    logic                    init_i;
    logic [NUM_WARP_LOG-1:0] init_warp_i;
    logic [SIZE_CORE-1:0]    init_mask_i;
    logic [NUM_WARP_LOG-1:0] lookup_warp_i;
    logic [SIZE_CORE-1:0]    active_mask_o;
    logic [SIZE_PC-1:0]      top_rpc_o;
    logic                    reconv_i;
    logic [NUM_WARP_LOG-1:0] reconv_warp_i;
    logic                    br_valid_i;
    logic [NUM_WARP_LOG-1:0] br_warp_i;
    logic [SIZE_CORE-1:0]    br_taken_i;
    logic [SIZE_PC-1:0]      br_target_i;
    logic [SIZE_PC-1:0]      br_fallthru_i;
    logic [SIZE_PC-1:0]      br_rpc_i;
    logic                    exit_i;
    logic [NUM_WARP_LOG-1:0] exit_warp_i;
    logic                    redirect_valid_o;
    logic [NUM_WARP_LOG-1:0] redirect_warp_o;
    logic [SIZE_PC-1:0]      redirect_pc_o;
    logic                    overflow_o;
    logic                    collide_o;

    modport master (
        output init_i, init_warp_i, init_mask_i, lookup_warp_i,
        output reconv_i, reconv_warp_i,
        output br_valid_i, br_warp_i, br_taken_i, br_target_i, br_fallthru_i, br_rpc_i,
        output exit_i, exit_warp_i,
        input  active_mask_o, top_rpc_o,
        input  redirect_valid_o, redirect_warp_o, redirect_pc_o, overflow_o, collide_o
    );

    modport slave (
        input  init_i, init_warp_i, init_mask_i, lookup_warp_i,
        input  reconv_i, reconv_warp_i,
        input  br_valid_i, br_warp_i, br_taken_i, br_target_i, br_fallthru_i, br_rpc_i,
        input  exit_i, exit_warp_i,
        output active_mask_o, top_rpc_o,
        output redirect_valid_o, redirect_warp_o, redirect_pc_o, overflow_o, collide_o
    );
endinterface

// File: rtl/simt_reconv_stack.sv
// Per-warp SIMT reconvergence stack: pushes on divergent branches, pops on reconvergence,
// exposes the top-of-stack mask/RPC for the issuing warp and redirects fetch on a pop.
module simt_reconv_stack #(
    parameter int NUM_WARP_LOG = 3,
    parameter int SIZE_CORE    = 8,
    parameter int SIZE_PC      = 32,
    parameter int DEPTH_LOG    = 2
) (
    input logic               clk,
    input logic               reset,
    simt_reconv_stack_if.slave bus
);
    localparam int NUM_WARP = 1 << NUM_WARP_LOG;
    localparam int DEPTH    = 1 << DEPTH_LOG;

    typedef logic [DEPTH_LOG-1:0]   sp_t;
    typedef logic [DEPTH_LOG:0]     sp_wide_t;
    typedef logic [NUM_WARP_LOG-1:0] warp_t;

    logic [SIZE_CORE-1:0] top_mask [NUM_WARP];
    logic [SIZE_PC-1:0]   top_rpc  [NUM_WARP];
    logic [SIZE_PC-1:0]   pop_pc   [NUM_WARP];
    logic [NUM_WARP-1:0]  pop_vec;
    logic [NUM_WARP-1:0]  ovf_vec;

    logic                 collide_event;
    logic                 redirect_valid_reg;
    warp_t                redirect_warp_reg;
    logic [SIZE_PC-1:0]   redirect_pc_reg;
    logic                 overflow_reg;
    logic                 collide_reg;

    always_comb begin
        collide_event = (bus.br_valid_i && bus.reconv_i && (bus.br_warp_i == bus.reconv_warp_i))
                     || (bus.init_i && bus.exit_i && (bus.init_warp_i == bus.exit_warp_i));
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARP; gi++) begin : g_warp
            logic [SIZE_CORE-1:0] mask_mem [DEPTH];
            logic [SIZE_PC-1:0]   rpc_mem  [DEPTH];
            logic [SIZE_PC-1:0]   pc_mem   [DEPTH];
            sp_t                  sp_reg, sp_next;
            logic                 valid_reg, valid_next;
            logic                 init_hit, exit_hit, br_hit, rc_hit;
            logic                 live, divergent, no_room, push, pop, ovf;
            sp_t                  sp_p1, sp_p2, sp_m1;

            always_comb begin
                init_hit  = bus.init_i     && (bus.init_warp_i   == warp_t'(gi));
                exit_hit  = bus.exit_i     && (bus.exit_warp_i   == warp_t'(gi));
                br_hit    = bus.br_valid_i && (bus.br_warp_i     == warp_t'(gi));
                rc_hit    = bus.reconv_i   && (bus.reconv_warp_i == warp_t'(gi));
                sp_p1     = sp_reg + sp_t'(1);
                sp_p2     = sp_reg + sp_t'(2);
                sp_m1     = sp_reg - sp_t'(1);
                // Branch and reconv only act on a running warp that is not being (re)launched or retired.
                live      = valid_reg && !init_hit && !exit_hit;
                divergent = (bus.br_taken_i != '0) && (bus.br_taken_i != mask_mem[sp_reg]);
                no_room   = (sp_wide_t'(sp_reg) + sp_wide_t'(2)) > sp_wide_t'(DEPTH - 1);
                push      = live && br_hit && divergent && !no_room;
                ovf       = live && br_hit && divergent && no_room;
                // A same-warp branch wins over the reconv pulse.
                pop       = live && rc_hit && !br_hit && (sp_reg != '0);
            end

            always_comb begin
                sp_next    = sp_reg;
                valid_next = valid_reg;
                if (init_hit) begin
                    sp_next    = '0;
                    valid_next = 1'b1;
                end else if (exit_hit) begin
                    sp_next    = '0;
                    valid_next = 1'b0;
                end else if (push) begin
                    sp_next = sp_p2;
                end else if (pop) begin
                    sp_next = sp_m1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sp_reg    <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    sp_reg    <= sp_next;
                    valid_reg <= valid_next;
                end
            end

            // Entry storage needs no reset: the valid bit gates every read.
            always_ff @(posedge clk) begin
                if (init_hit) begin
                    mask_mem[0] <= bus.init_mask_i;
                    rpc_mem[0]  <= '1;
                    pc_mem[0]   <= '0;
                end else if (push) begin
                    pc_mem[sp_reg]  <= bus.br_rpc_i;
                    mask_mem[sp_p1] <= mask_mem[sp_reg] & ~bus.br_taken_i;
                    rpc_mem[sp_p1]  <= bus.br_rpc_i;
                    pc_mem[sp_p1]   <= bus.br_fallthru_i;
                    mask_mem[sp_p2] <= bus.br_taken_i;
                    rpc_mem[sp_p2]  <= bus.br_rpc_i;
                    pc_mem[sp_p2]   <= bus.br_target_i;
                end
            end

            assign top_mask[gi] = valid_reg ? mask_mem[sp_reg] : '0;
            assign top_rpc[gi]  = valid_reg ? rpc_mem[sp_reg]  : '1;
            assign pop_pc[gi]   = pc_mem[sp_m1];
            assign pop_vec[gi]  = pop;
            assign ovf_vec[gi]  = ovf;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_valid_reg <= 1'b0;
            redirect_warp_reg  <= '0;
            redirect_pc_reg    <= '0;
            overflow_reg       <= 1'b0;
            collide_reg        <= 1'b0;
        end else begin
            redirect_valid_reg <= |pop_vec;
            if (|pop_vec) begin
                redirect_warp_reg <= bus.reconv_warp_i;
                redirect_pc_reg   <= pop_pc[bus.reconv_warp_i];
            end
            overflow_reg <= overflow_reg | (|ovf_vec);
            collide_reg  <= collide_reg | collide_event;
        end
    end

    assign bus.active_mask_o    = top_mask[bus.lookup_warp_i];
    assign bus.top_rpc_o        = top_rpc[bus.lookup_warp_i];
    assign bus.redirect_valid_o = redirect_valid_reg;
    assign bus.redirect_warp_o  = redirect_warp_reg;
    assign bus.redirect_pc_o    = redirect_pc_reg;
    assign bus.overflow_o       = overflow_reg;
    assign bus.collide_o        = collide_reg;
endmodule

// File: tb/tb_simt_reconv_stack.sv
// Bench for simt_reconv_stack: directed scenarios then random traffic, checked against a
// list-of-entries stack model with a redirect scoreboard drained by a separate monitor.
module tb_simt_reconv_stack;
    localparam int NW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    simt_reconv_stack_if #(.NUM_WARP_LOG(3), .SIZE_CORE(8), .SIZE_PC(32)) bus ();

    simt_reconv_stack #(.NUM_WARP_LOG(3), .SIZE_CORE(8), .SIZE_PC(32), .DEPTH_LOG(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  mask;
        logic [31:0] rpc;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        int          warp;
        logic [31:0] pc;
        int          at;
    } redir_t;

    ent_t   mstk [NW][DEPTH];
    int     mcnt [NW];
    bit     mvalid [NW];
    bit     m_ovf, m_col;
    redir_t sbq [$];
    redir_t mon_r;
    int     checks = 0;
    int     failures = 0;
    int     neg_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_mask(input int w);
        return mvalid[w] ? mstk[w][mcnt[w]-1].mask : 8'h00;
    endfunction

    function automatic logic [31:0] m_rpc(input int w);
        return mvalid[w] ? mstk[w][mcnt[w]-1].rpc : 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            mvalid[w] = 1'b0;
            mcnt[w]   = 0;
        end
        m_ovf = 1'b0;
        m_col = 1'b0;
        sbq.delete();
    endtask

    // Applies the events currently on the bus, one warp at a time.
    task automatic model_apply();
        bit ih, eh, bh, rh;
        logic [7:0] a, t;
        if (bus.br_valid_i && bus.reconv_i && bus.br_warp_i == bus.reconv_warp_i) m_col = 1'b1;
        if (bus.init_i && bus.exit_i && bus.init_warp_i == bus.exit_warp_i) m_col = 1'b1;
        for (int w = 0; w < NW; w++) begin
            ih = bus.init_i     && (int'(bus.init_warp_i)   == w);
            eh = bus.exit_i     && (int'(bus.exit_warp_i)   == w);
            bh = bus.br_valid_i && (int'(bus.br_warp_i)     == w);
            rh = bus.reconv_i   && (int'(bus.reconv_warp_i) == w);
            if (ih) begin
                mvalid[w]  = 1'b1;
                mcnt[w]    = 1;
                mstk[w][0] = '{mask: bus.init_mask_i, rpc: 32'hFFFF_FFFF, pc: 32'h0};
            end else if (eh) begin
                mvalid[w] = 1'b0;
                mcnt[w]   = 0;
            end else if (mvalid[w]) begin
                if (bh) begin
                    a = mstk[w][mcnt[w]-1].mask;
                    t = bus.br_taken_i;
                    if (t != 8'h00 && t != a) begin
                        if (mcnt[w] + 2 > DEPTH) begin
                            m_ovf = 1'b1;
                        end else begin
                            mstk[w][mcnt[w]-1].pc = bus.br_rpc_i;
                            mstk[w][mcnt[w]]   = '{mask: a & ~t, rpc: bus.br_rpc_i, pc: bus.br_fallthru_i};
                            mstk[w][mcnt[w]+1] = '{mask: t, rpc: bus.br_rpc_i, pc: bus.br_target_i};
                            mcnt[w] += 2;
                        end
                    end
                end else if (rh && mcnt[w] > 1) begin
                    mcnt[w]--;
                    sbq.push_back('{warp: w, pc: mstk[w][mcnt[w]-1].pc, at: neg_count + 1});
                end
            end
        end
    endtask

    task automatic clear_inputs();
        bus.init_i = 0;      bus.init_warp_i = 0;   bus.init_mask_i = 0;
        bus.reconv_i = 0;    bus.reconv_warp_i = 0;
        bus.br_valid_i = 0;  bus.br_warp_i = 0;     bus.br_taken_i = 0;
        bus.br_target_i = 0; bus.br_fallthru_i = 0; bus.br_rpc_i = 0;
        bus.exit_i = 0;      bus.exit_warp_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_apply();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic look(input int w);
        bus.lookup_warp_i = 3'(w);
        #1;
        chk($sformatf("mask_w%0d", w), 64'(bus.active_mask_o), 64'(m_mask(w)));
        chk($sformatf("rpc_w%0d", w), 64'(bus.top_rpc_o), 64'(m_rpc(w)));
        chk("overflow", 64'(bus.overflow_o), 64'(m_ovf));
        chk("collide", 64'(bus.collide_o), 64'(m_col));
    endtask

    task automatic set_br(input int w, input logic [7:0] t, input logic [31:0] tgt,
                          input logic [31:0] ft, input logic [31:0] rpc);
        bus.br_valid_i = 1; bus.br_warp_i = 3'(w); bus.br_taken_i = t;
        bus.br_target_i = tgt; bus.br_fallthru_i = ft; bus.br_rpc_i = rpc;
    endtask

    task automatic set_init(input int w, input logic [7:0] m);
        bus.init_i = 1; bus.init_warp_i = 3'(w); bus.init_mask_i = m;
    endtask

    task automatic set_reconv(input int w);
        bus.reconv_i = 1; bus.reconv_warp_i = 3'(w);
    endtask

    // Redirect monitor: every pulse must match the oldest expected pop, on the expected cycle.
    always @(negedge clk) begin
        neg_count++;
        if (bus.redirect_valid_o === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL redirect_unexpected actual=warp %0d pc %h required=no redirect",
                         bus.redirect_warp_o, bus.redirect_pc_o);
            end else begin
                mon_r = sbq.pop_front();
                chk("redirect_warp", 64'(bus.redirect_warp_o), 64'(mon_r.warp));
                chk("redirect_pc", 64'(bus.redirect_pc_o), 64'(mon_r.pc));
                chk("redirect_cycle", 64'(neg_count), 64'(mon_r.at));
            end
        end else if (sbq.size() > 0 && sbq[0].at <= neg_count) begin
            mon_r = sbq.pop_front();
            checks++;
            failures++;
            $display("FAIL redirect_missing actual=no redirect required=warp %0d pc %h",
                     mon_r.warp, mon_r.pc);
        end
    end

    initial begin
        logic [7:0] a;
        int w;
        reset = 1'b1;
        bus.lookup_warp_i = 0;
        clear_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        look(2);
        chk("reset_redirect_valid", 64'(bus.redirect_valid_o), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Launch w2 with all threads.
        set_init(2, 8'hFF); tick(); look(2);
        chk("init_mask_const", 64'(bus.active_mask_o), 64'hFF);
        chk("init_rpc_const", 64'(bus.top_rpc_o), 64'hFFFF_FFFF);

        // Divergent branch then two pops.
        set_br(2, 8'h0F, 32'h40, 32'h20, 32'h80); tick(); look(2);
        chk("div_mask_const", 64'(bus.active_mask_o), 64'h0F);
        set_reconv(2); tick(); look(2);
        chk("pop1_mask_const", 64'(bus.active_mask_o), 64'hF0);
        set_reconv(2); tick(); look(2);
        chk("pop2_mask_const", 64'(bus.active_mask_o), 64'hFF);

        // Uniform branches leave the stack alone; a reconv at sp 0 is ignored.
        set_br(2, 8'hFF, 32'h100, 32'h104, 32'h108); tick(); look(2);
        set_br(2, 8'h00, 32'h100, 32'h104, 32'h108); tick(); look(2);
        set_reconv(2); tick(); look(2);

        // Nested divergence on w1 overflows the 4-entry stack.
        set_init(1, 8'hFF); tick();
        set_br(1, 8'h0F, 32'h100, 32'h200, 32'h300); tick(); look(1);
        set_br(1, 8'h03, 32'h400, 32'h500, 32'h600); tick(); look(1);
        chk("overflow_const", 64'(bus.overflow_o), 64'h1);

        // Same-warp branch+reconv collides; different-warp events proceed independently.
        set_init(3, 8'hFF); tick();
        set_init(4, 8'hFF); tick();
        set_br(4, 8'h0F, 32'h44, 32'h48, 32'h4C); tick();
        set_br(3, 8'h33, 32'h30, 32'h34, 32'h38); set_reconv(3); tick(); look(3);
        chk("collide_const", 64'(bus.collide_o), 64'h1);
        set_br(3, 8'h01, 32'h50, 32'h54, 32'h58); set_reconv(4); tick(); look(3); look(4);

        // Reset right after a pop suppresses the pending redirect.
        set_reconv(4);
        @(posedge clk);
        model_apply();
        #1 reset = 1'b1;
        model_reset();
        @(negedge clk);
        clear_inputs();
        for (int i = 0; i < NW; i++) begin
            bus.lookup_warp_i = 3'(i);
            #0.5;
            chk($sformatf("reset_mask_w%0d", i), 64'(bus.active_mask_o), 64'h0);
        end
        chk("reset_redirect_after_pop", 64'(bus.redirect_valid_o), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(99) < 15) set_init($urandom_range(NW-1), 8'($urandom_range(255, 1)));
            if ($urandom_range(99) < 5) begin
                bus.exit_i = 1; bus.exit_warp_i = 3'($urandom_range(NW-1));
            end
            if ($urandom_range(99) < 40) begin
                w = $urandom_range(NW-1);
                a = m_mask(w);
                case ($urandom_range(3))
                    0:       set_br(w, 8'h00, $urandom, $urandom, $urandom);
                    1:       set_br(w, a, $urandom, $urandom, $urandom);
                    default: set_br(w, a & 8'($urandom), $urandom, $urandom, $urandom);
                endcase
            end
            if ($urandom_range(99) < 40) set_reconv($urandom_range(NW-1));
            tick();
            look($urandom_range(NW-1));
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
